decode_hazard_ctrl: RTL and testbench

DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

---
 rtl/decode_hazard_ctrl.sv | 94 +++++++++
 tb/tb_decode_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_ctrl.sv
// rtl/decode_hazard_ctrl.sv - decode-stage hazard controller: load-use stall, branch flush, forwarding select
// Tracks the three in-flight stages (EX, MEM, WB) and derives stall/flush/issue plus operand bypass selects.
module decode_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic             issue,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t     state;
  logic [2:0] slot_valid;
  logic [2:0] slot_we;
  logic [2:0] slot_load;
  logic [4:0] slot_rd [3];
  logic [2:0] match1;
  logic [2:0] match2;
  logic       load_use;

  // Slot index 0 is EX, 1 is MEM, 2 is WB.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < 3; i++) begin
      match1[i] = slot_valid[i] && slot_we[i] && (slot_rd[i] == id_rs1) &&
                  (id_rs1 != 5'd0) && id_rs1_used;
      match2[i] = slot_valid[i] && slot_we[i] && (slot_rd[i] == id_rs2) &&
                  (id_rs2 != 5'd0) && id_rs2_used;
    end
  end

  // A load in EX cannot bypass; fall through to older producers instead.
  function automatic logic [1:0] pick_src(input logic [2:0] m, input logic ex_load);
    if (m[0] && !ex_load)
      return 2'b01;
    else if (m[1])
      return 2'b10;
    else if (m[2])
      return 2'b11;
    else
      return 2'b00;
  endfunction

  always_comb begin
    load_use = id_valid && slot_load[0] && (match1[0] || match2[0]);
    flush    = ex_branch_taken || (state == FLUSH);
    stall    = load_use && !flush;
    issue    = id_valid && !stall && !flush;
    fwd_sel1 = pick_src(match1, slot_load[0]);
    fwd_sel2 = pick_src(match2, slot_load[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      slot_valid <= '0;
      slot_we    <= '0;
      slot_load  <= '0;
      for (int i = 0; i < 3; i++) slot_rd[i] <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      slot_valid <= {slot_valid[1:0], issue};
      slot_we    <= {slot_we[1:0],    issue && id_rd_we};
      slot_load  <= {slot_load[1:0],  issue && id_is_load};
      slot_rd[2] <= slot_rd[1];
      slot_rd[1] <= slot_rd[0];
      slot_rd[0] <= issue ? id_rd : 5'd0;
      state      <= ex_branch_taken ? FLUSH : RUN;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb/tb_decode_hazard_ctrl.sv - self-checking bench for decode_hazard_ctrl
// Directed scenarios plus randomized traffic against a pipeline-history reference model.
module tb_decode_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_rd_we;
  logic             id_is_load;
  logic             ex_branch_taken;
  logic             stall;
  logic             flush;
  logic             issue;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  decode_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush(flush), .issue(issue),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of the last three issued (or bubbled) instructions, youngest first.
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } instr_t;

  instr_t hist [3];
  bit     m_branch_shadow;
  int     m_stall_cnt;
  int     m_flush_cnt;
  bit       e_stall, e_flush, e_issue;
  bit [1:0] e_sel1, e_sel2;

  function automatic bit writes(input instr_t p, input bit [4:0] rs, input bit used);
    return p.v && p.we && used && (rs != 0) && (p.rd == rs);
  endfunction

  function automatic bit [1:0] youngest_source(input bit [4:0] rs, input bit used);
    for (int age = 0; age < 3; age++)
      if (writes(hist[age], rs, used) && !(age == 0 && hist[age].ld))
        return 2'(age + 1);
    return 2'b00;
  endfunction

  function automatic void model_eval();
    bit lu;
    lu = id_valid && hist[0].ld &&
         (writes(hist[0], id_rs1, id_rs1_used) || writes(hist[0], id_rs2, id_rs2_used));
    e_flush = ex_branch_taken || m_branch_shadow;
    e_stall = lu && !e_flush;
    e_issue = id_valid && !e_stall && !e_flush;
    e_sel1  = youngest_source(id_rs1, id_rs1_used);
    e_sel2  = youngest_source(id_rs2, id_rs2_used);
  endfunction

  task automatic tick();
    instr_t nxt;
    model_eval();
    nxt = e_issue ? instr_t'{1'b1, id_rd, id_rd_we, id_is_load} : instr_t'(0);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = instr_t'(0);
      m_branch_shadow = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nxt;
      m_branch_shadow = ex_branch_taken;
      if (e_stall && m_stall_cnt < MAXC) m_stall_cnt++;
      if (e_flush && m_flush_cnt < MAXC) m_flush_cnt++;
    end
    #1;
  endtask

  task automatic set_in(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                        input bit u2, input bit [4:0] rd, input bit we, input bit ld, input bit br);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; ex_branch_taken = br;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); tick(); tick(); rst = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0d exp 0", flush); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue got %0d exp 0", issue); end
    checks++; if (fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
      errors++; $display("FAIL reset_fwd got %0d/%0d exp 0/0", fwd_sel1, fwd_sel2); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL lu_load_issue got %0d exp 1", issue); end
    tick();
    set_in(1, 5, 1, 0, 0, 9, 1, 0, 0); #1;
    checks++; if (stall !== 1'b1 || issue !== 1'b0) begin
      errors++; $display("FAIL lu_stall got stall=%0d issue=%0d exp 1/0", stall, issue); end
    tick();
    checks++; if (stall !== 1'b0 || issue !== 1'b1 || fwd_sel1 !== 2'b10) begin
      errors++; $display("FAIL lu_reissue got stall=%0d issue=%0d sel1=%0d exp 0/1/2", stall, issue, fwd_sel1); end
    tick();
    checks++; if (stall_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_forward();
    bit [1:0] exp_tab [4];
    exp_tab = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int gap = 0; gap < 4; gap++) begin
      do_reset();
      set_in(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
      for (int b = 0; b < gap; b++) begin idle(); tick(); end
      set_in(1, 0, 0, 3, 1, 8, 1, 0, 0); #1;
      checks++; if (stall !== 1'b0 || fwd_sel2 !== exp_tab[gap]) begin
        errors++; $display("FAIL fwd_gap%0d got stall=%0d sel2=%0d exp 0/%0d", gap, stall, fwd_sel2, exp_tab[gap]); end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 1); #1;
    checks++; if (flush !== 1'b1 || issue !== 1'b0) begin
      errors++; $display("FAIL br_cycle1 got flush=%0d issue=%0d exp 1/0", flush, issue); end
    tick();
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); #1;
    checks++; if (flush !== 1'b1 || issue !== 1'b0) begin
      errors++; $display("FAIL br_cycle2 got flush=%0d issue=%0d exp 1/0", flush, issue); end
    tick();
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (flush !== 1'b0 || issue !== 1'b1 || fwd_sel1 !== 2'b00) begin
      errors++; $display("FAIL br_after got flush=%0d issue=%0d sel1=%0d exp 0/1/0", flush, issue, fwd_sel1); end
    checks++; if (flush_cnt !== CNT_W'(2)) begin
      errors++; $display("FAIL br_flush_cnt got %0d exp 2", flush_cnt); end
    tick();
  endtask

  task automatic test_lu_branch();
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 1); #1;
    checks++; if (stall !== 1'b0 || flush !== 1'b1 || issue !== 1'b0) begin
      errors++; $display("FAIL lubr got stall=%0d flush=%0d issue=%0d exp 0/1/0", stall, flush, issue); end
    tick();
    checks++; if (stall_cnt !== '0) begin
      errors++; $display("FAIL lubr_stall_cnt got %0d exp 0", stall_cnt); end
    idle(); tick();
  endtask

  task automatic test_x0_double_branch();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    set_in(1, 0, 1, 0, 1, 4, 1, 0, 0); #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1 || fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
      errors++; $display("FAIL x0 got stall=%0d issue=%0d sel=%0d/%0d exp 0/1/0/0", stall, issue, fwd_sel1, fwd_sel2); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    tick();
    idle(); #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL dbl_br_extend got %0d exp 1", flush); end
    tick();
    checks++; if (flush !== 1'b0 || flush_cnt !== CNT_W'(3)) begin
      errors++; $display("FAIL dbl_br_end got flush=%0d cnt=%0d exp 0/3", flush, flush_cnt); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    rst = 1; idle(); tick(); rst = 0; #1;
    checks++; if (flush !== 1'b0 || flush_cnt !== '0) begin
      errors++; $display("FAIL rst_mid_flush got flush=%0d cnt=%0d exp 0/0", flush, flush_cnt); end
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall_pre got %0d exp 1", stall); end
    rst = 1; tick(); rst = 0; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin
      errors++; $display("FAIL rst_mid_stall got stall=%0d issue=%0d exp 0/1", stall, issue); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    set_in(1, 5, 1, 0, 0, 5, 1, 1, 0);
    for (int i = 0; i < 40; i++) begin
      #1;
      checks++; if (stall !== bit'(i % 2)) begin
        errors++; $display("FAIL sat_pattern cyc%0d got %0d exp %0d", i, stall, i % 2); end
      tick();
    end
    checks++; if (stall_cnt !== CNT_W'(MAXC) || flush_cnt !== '0) begin
      errors++; $display("FAIL sat_cnt got %0d/%0d exp %0d/0", stall_cnt, flush_cnt, MAXC); end
    rst = 1; tick(); rst = 0;
    set_in(1, 5, 1, 5, 1, 0, 0, 0, 0); #1;
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL sat_rst_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    checks++; if (stall !== 1'b0 || fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
      errors++; $display("FAIL sat_rst_slots got stall=%0d sel=%0d/%0d exp 0/0/0", stall, fwd_sel1, fwd_sel2); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom % 64) == 0;
      set_in(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), ($urandom % 8) == 0);
      #1;
      model_eval();
      checks++; if ({stall, flush, issue, fwd_sel1, fwd_sel2} !== {e_stall, e_flush, e_issue, e_sel1, e_sel2}) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d got s=%0d f=%0d i=%0d %0d/%0d exp s=%0d f=%0d i=%0d %0d/%0d", n,
                 stall, flush, issue, fwd_sel1, fwd_sel2, e_stall, e_flush, e_issue, e_sel1, e_sel2);
      end
      checks++; if (stall_cnt !== CNT_W'(m_stall_cnt) || flush_cnt !== CNT_W'(m_flush_cnt)) begin
        errors++; $display("FAIL rand_cnt cyc%0d got %0d/%0d exp %0d/%0d", n, stall_cnt, flush_cnt,
                           m_stall_cnt, m_flush_cnt);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = instr_t'(0);
    m_branch_shadow = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    rst = 1; idle();
    #1;
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_lu_branch();
    test_x0_double_branch();
    test_reset_mid_op();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
